axi_lite_wr_master: RTL
=======================

Name: axi_lite_wr_master

Overview:
- Parametrised AXI-Lite write-channel master engine; successor to the single-shot, hand-driven awvalid/wvalid logic currently placed directly in client modules.
- Accepts write commands on a simple valid/ready port and drives the AW/W/B channels of an AXI-Lite master.
- Drives AW and W independently and tracks up to MAX_OUTSTANDING unacknowledged writes.
- Returns each B response to the client and keeps an error count.

Parameters:
- ADDR_WIDTH, 32: address width in bits.
- DATA_WIDTH, 32: data width in bits; legal values are 32 and 64. STRB_WIDTH = DATA_WIDTH/8.
- MAX_OUTSTANDING, 4: maximum issued writes without a B response; range 1..15.
- ERR_CNT_WIDTH, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  client write request
- cmd_ready  out  1  engine accepts the request
- cmd_addr  in  ADDR_WIDTH  write address
- cmd_data  in  DATA_WIDTH  write data
- cmd_strb  in  STRB_WIDTH  byte strobes
- rsp_valid  out  1  one-cycle pulse, a B response has arrived
- rsp_resp  out  2  BRESP value, valid with rsp_valid
- awaddr  out  ADDR_WIDTH  AXI AW address
- awvalid  out  1  AXI AW valid
- awready  in  1  AXI AW ready
- wdata  out  DATA_WIDTH  AXI W data
- wstrb  out  STRB_WIDTH  AXI W strobes
- wvalid  out  1  AXI W valid
- wready  in  1  AXI W ready
- bresp  in  2  AXI B response
- bvalid  in  1  AXI B valid
- bready  out  1  AXI B ready
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current count of in-flight writes
- err_count  out  ERR_CNT_WIDTH  saturating count of non-OKAY responses
- proto_err  out  1  sticky flag, bvalid seen with outstanding==0

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0, except bready, which is 1. awaddr, wdata and wstrb clear to 0. All pending flags and counters clear. A reset mid-transaction drops all in-flight state with no response.

Command acceptance:
- cmd_ready = !aw_pend && !w_pend && (outstanding < MAX_OUTSTANDING). This is combinational from registers only.
- Fire = cmd_valid && cmd_ready.
- On fire: latch addr/data/strb into awaddr/wdata/wstrb, set aw_pend and w_pend, and increment outstanding.
- awvalid and wvalid assert the cycle after fire. Latency is 1 cycle from fire to valid.

AW channel (state IDLE/PEND via aw_pend):
- awvalid = aw_pend.
- awaddr is held stable while awvalid is high.
- awvalid never deasserts before awready.
- aw_pend clears on awvalid && awready.

W channel (independent of AW):
- wvalid = w_pend.
- wdata and wstrb are held stable while wvalid is high.
- w_pend clears on wvalid && wready.
- AW and W may complete in either order or in the same cycle.
- The next command is accepted only after both handshakes complete. The earliest fire is the cycle after the later handshake.

B channel:
- bready is constant 1 out of reset.
- On bvalid: rsp_valid pulses 1 cycle later, with rsp_resp = the registered bresp, and outstanding decrements.

Counting and errors:
- If fire and a B handshake occur in the same cycle, outstanding is unchanged.
- bvalid with outstanding==0: outstanding stays 0, proto_err sets and stays set until reset, and rsp_valid still pulses.
- bresp != 2'b00: err_count increments and saturates at all-ones (no wrap).
- With MAX_OUTSTANDING reached, cmd_ready stays 0 until a B arrives. With MAX_OUTSTANDING==1 the engine is fully serial.

Decomposition:
- Shared package axi_lite_pkg:
  - resp_e enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
  - RESP_WIDTH=2 constant
  - aw_req_t / w_req_t struct typedefs, parametrised through localparams in users
- Sub-module axi_lite_hold_chan: a generic valid-hold register with a payload parameter, instantiated twice (AW, W).
- Counter and error logic stay in the top module.

Test Plan:
- Single write, ADDR=0x0000_1000, DATA=0xDEAD_BEEF, STRB=0xF, awready=wready=1, bvalid with OKAY 3 cycles later -> awvalid and wvalid high for exactly 1 cycle; rsp_valid pulses with rsp_resp=0; outstanding goes 0->1->0; cmd_ready low only while pending.
- W accepted 4 cycles before AW (awready held low) -> awaddr stable throughout; wvalid drops after its handshake; cmd_ready rises the cycle after the AW handshake.
- MAX_OUTSTANDING=4, bvalid withheld, 6 back-to-back commands with immediate ready -> exactly 4 accepted; outstanding=4; cmd_ready=0; one B then frees one slot; 5th accepted.
- Fire and B handshake in the same cycle with outstanding=2 -> outstanding remains 2.
- 300 SLVERR responses with ERR_CNT_WIDTH=8 -> err_count saturates at 255.
- Spurious bvalid at outstanding=0 -> proto_err=1 and stays 1; outstanding=0.
- Reset asserted while awvalid=1 -> awvalid, wvalid and outstanding are 0 immediately.
- After reset release -> cmd_ready=1 on the first clock.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response encoding and the per-channel
// handshake state used by the write master and its hold registers.
package axi_lite_pkg;

    localparam int RESP_WIDTH = 2;

    typedef enum logic [RESP_WIDTH-1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    typedef enum logic {
        CHAN_IDLE = 1'b0,
        CHAN_PEND = 1'b1
    } chan_state_e;

    // Anything other than OKAY is counted as an error, EXOKAY included.
    function automatic logic resp_is_err(input logic [RESP_WIDTH-1:0] resp);
        return resp != OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_hold_chan.sv
// Valid-hold register for one AXI channel: captures a payload on load and
// keeps valid and payload stable until the slave's ready completes the handshake.
module axi_lite_hold_chan
    import axi_lite_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_payload,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_payload
);

    chan_state_e      r_state;
    chan_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_payload;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CHAN_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: default assigned first so no path through the case can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CHAN_IDLE: if (i_load)  w_state_nxt = CHAN_PEND;
            CHAN_PEND: if (i_ready) w_state_nxt = CHAN_IDLE;
            default:                w_state_nxt = CHAN_IDLE;
        endcase
    end

    // NOTE: a plain payload register (not a memory array), so it carries a reset to a known 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_payload <= '0;
        end else if (i_load && (r_state == CHAN_IDLE)) begin
            r_payload <= i_payload;
        end
    end

    assign o_valid   = (r_state == CHAN_PEND);
    assign o_payload = r_payload;

endmodule

// File: rtl/axi_lite_wr_master.sv
// AXI-Lite write master: one client command at a time onto AW/W, up to
// MAX_OUTSTANDING B responses in flight, saturating error count, protocol flag.
module axi_lite_wr_master
    import axi_lite_pkg::*;
#(
    parameter  int ADDR_WIDTH      = 32,
    parameter  int DATA_WIDTH      = 32,
    parameter  int MAX_OUTSTANDING = 4,
    parameter  int ERR_CNT_WIDTH   = 8,
    localparam int STRB_WIDTH      = DATA_WIDTH / 8,
    localparam int OUT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_data,
    input  logic [STRB_WIDTH-1:0]    cmd_strb,
    output logic                     rsp_valid,
    output logic [RESP_WIDTH-1:0]    rsp_resp,
    output logic [ADDR_WIDTH-1:0]    awaddr,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [DATA_WIDTH-1:0]    wdata,
    output logic [STRB_WIDTH-1:0]    wstrb,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [RESP_WIDTH-1:0]    bresp,
    input  logic                     bvalid,
    output logic                     bready,
    output logic [OUT_WIDTH-1:0]     outstanding,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     proto_err
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
    } aw_req_t;

    typedef struct packed {
        logic [STRB_WIDTH-1:0] strb;
        logic [DATA_WIDTH-1:0] data;
    } w_req_t;

    localparam int AW_BITS = $bits(aw_req_t);
    localparam int W_BITS  = $bits(w_req_t);

    logic                     r_run;
    logic [OUT_WIDTH-1:0]     r_outstanding;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;
    logic                     r_proto_err;
    logic                     r_rsp_valid;
    logic [RESP_WIDTH-1:0]    r_rsp_resp;

    logic    w_fire;
    logic    w_b_hs;
    logic    w_b_counted;
    logic    w_has_room;
    aw_req_t w_aw_in;
    aw_req_t w_aw_out;
    w_req_t  w_w_in;
    w_req_t  w_w_out;

    assign w_aw_in = '{addr: cmd_addr};
    assign w_w_in  = '{strb: cmd_strb, data: cmd_data};

    axi_lite_hold_chan #(.WIDTH(AW_BITS)) u_aw_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_fire),
        .i_payload (w_aw_in),
        .i_ready   (awready),
        .o_valid   (awvalid),
        .o_payload (w_aw_out)
    );

    axi_lite_hold_chan #(.WIDTH(W_BITS)) u_w_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_fire),
        .i_payload (w_w_in),
        .i_ready   (wready),
        .o_valid   (wvalid),
        .o_payload (w_w_out)
    );

    assign awaddr = w_aw_out.addr;
    assign wdata  = w_w_out.data;
    assign wstrb  = w_w_out.strb;

    // r_run keeps cmd_ready low while in reset; it rises on the first clock after release.
    assign w_has_room  = r_outstanding < OUT_WIDTH'(MAX_OUTSTANDING);
    assign cmd_ready   = r_run && !awvalid && !wvalid && w_has_room;
    assign w_fire      = cmd_valid && cmd_ready;
    assign bready      = 1'b1;
    assign w_b_hs      = bvalid && bready;
    assign w_b_counted = w_b_hs && (r_outstanding != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_outstanding <= '0;
            r_err_count   <= '0;
            r_proto_err   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_resp    <= '0;
        end else begin
            r_run       <= 1'b1;
            r_rsp_valid <= w_b_hs;
            if (w_b_hs) begin
                r_rsp_resp <= bresp;
            end
            // A fire and a counted B in the same cycle cancel out.
            case ({w_fire, w_b_counted})
                2'b10:   r_outstanding <= r_outstanding + OUT_WIDTH'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_WIDTH'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_b_hs && (r_outstanding == '0)) begin
                r_proto_err <= 1'b1;
            end
            if (w_b_hs && resp_is_err(bresp) && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_resp    = r_rsp_resp;
    assign outstanding = r_outstanding;
    assign err_count   = r_err_count;
    assign proto_err   = r_proto_err;

endmodule
